// File: rtl/dkong_dma_mc.sv
// dkong_dma_mc: multi-channel HRQ/HLDA block mover between dual-port RAMs with
// copy/fill modes, fixed-priority arbitration, bus-hold pausing and done pulses.
module dkong_dma_mc #(
    parameter int CHANNELS = 2,
    parameter int AW       = 10,
    parameter int LEN_W    = 10,
    parameter int DW       = 8
) (
    input  logic                      I_CLK,
    input  logic                      I_RESET,
    input  logic                      I_CLK_EN,
    input  logic [CHANNELS-1:0]       I_TRIG,
    input  logic [CHANNELS*AW-1:0]    I_CFG_SRC,
    input  logic [CHANNELS*AW-1:0]    I_CFG_DST,
    input  logic [CHANNELS*LEN_W-1:0] I_CFG_LEN,
    input  logic [CHANNELS-1:0]       I_CFG_MODE,
    input  logic [CHANNELS*DW-1:0]    I_FILL_D,
    input  logic                      I_HLDA,
    output logic                      O_HRQ,
    output logic [AW-1:0]             O_SRC_A,
    output logic                      O_SRC_CE,
    input  logic [DW-1:0]             I_SRC_D,
    output logic [AW-1:0]             O_DST_A,
    output logic [DW-1:0]             O_DST_D,
    output logic                      O_DST_WE,
    output logic                      O_BUSY,
    output logic [1:0]                O_ACT_CH,
    output logic [CHANNELS-1:0]       O_DONE
);
    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
    state_t state, state_n;
    logic [CHANNELS-1:0] prev_trig, pending, pending_n, rise, done_n, sel_mask;
    logic [LEN_W-1:0] k, k_n, len_l, len_n;
    logic [AW-1:0] src_l, src_n, dst_l, dst_n, src_a_n, dst_a_n;
    logic [DW-1:0] fill_l, fill_n, dst_d_n;
    logic mode_l, mode_n, hrq_n, src_ce_n, dst_we_n, found, last;
    logic [1:0] ch_l, ch_n, sel;

    assign rise = I_TRIG & ~prev_trig;

    always_comb begin
        found = 1'b0;
        sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (pending[i] && !found) begin
                found = 1'b1;
                sel = 2'(i);
            end
        sel_mask = CHANNELS'(1) << sel;
        state_n = state;
        pending_n = pending | rise;
        k_n = k;
        src_n = src_l;
        dst_n = dst_l;
        len_n = len_l;
        mode_n = mode_l;
        fill_n = fill_l;
        ch_n = ch_l;
        hrq_n = O_HRQ;
        src_ce_n = 1'b0;
        dst_we_n = 1'b0;
        done_n = '0;
        src_a_n = O_SRC_A;
        dst_a_n = O_DST_A;
        dst_d_n = O_DST_D;
        // copy ends on the step after the last read; fill on its last write
        last = mode_l ? (k + LEN_W'(1) == len_l) : (k == len_l);
        case (state)
            IDLE: if (found) begin
                pending_n = (pending & ~sel_mask) | rise;
                src_n = I_CFG_SRC[sel*AW +: AW];
                dst_n = I_CFG_DST[sel*AW +: AW];
                len_n = I_CFG_LEN[sel*LEN_W +: LEN_W];
                fill_n = I_FILL_D[sel*DW +: DW];
                mode_n = |(I_CFG_MODE & sel_mask);
                ch_n = sel;
                k_n = '0;
                if (len_n == '0) done_n = sel_mask;
                else begin
                    state_n = REQ;
                    hrq_n = 1'b1;
                end
            end
            REQ: if (I_HLDA) state_n = XFER;
            XFER: if (I_HLDA) begin
                k_n = k + LEN_W'(1);
                if (!mode_l && k != len_l) begin
                    src_ce_n = 1'b1;
                    src_a_n = src_l + AW'(k);
                end
                if (mode_l || k != '0) begin
                    dst_we_n = 1'b1;
                    dst_a_n = mode_l ? dst_l + AW'(k) : dst_l + AW'(k) - AW'(1);
                    dst_d_n = mode_l ? fill_l : I_SRC_D;
                end
                if (last) begin
                    state_n = IDLE;
                    hrq_n = 1'b0;
                    done_n = CHANNELS'(1) << ch_l;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state <= IDLE;
            prev_trig <= '0;
            pending <= '0;
            k <= '0;
            src_l <= '0;
            dst_l <= '0;
            len_l <= '0;
            mode_l <= 1'b0;
            fill_l <= '0;
            ch_l <= '0;
            O_HRQ <= 1'b0;
            O_SRC_A <= '0;
            O_SRC_CE <= 1'b0;
            O_DST_A <= '0;
            O_DST_D <= '0;
            O_DST_WE <= 1'b0;
            O_BUSY <= 1'b0;
            O_ACT_CH <= '0;
            O_DONE <= '0;
        end else begin
            // busy stays up through the done cycle and drops on the next clock
            O_BUSY <= state != IDLE || (I_CLK_EN && state_n != IDLE);
            if (I_CLK_EN) begin
                state <= state_n;
                prev_trig <= I_TRIG;
                pending <= pending_n;
                k <= k_n;
                src_l <= src_n;
                dst_l <= dst_n;
                len_l <= len_n;
                mode_l <= mode_n;
                fill_l <= fill_n;
                ch_l <= ch_n;
                O_HRQ <= hrq_n;
                O_SRC_A <= src_a_n;
                O_SRC_CE <= src_ce_n;
                O_DST_A <= dst_a_n;
                O_DST_D <= dst_d_n;
                O_DST_WE <= dst_we_n;
                O_ACT_CH <= ch_n;
                O_DONE <= done_n;
            end else begin
                O_SRC_CE <= 1'b0;
                O_DST_WE <= 1'b0;
                O_DONE <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dkong_dma_mc.sv
// tb_dkong_dma_mc: directed and randomized stimulus checked every clock
// against a transfer-level behavioural model of the DMA engine.
module tb_dkong_dma_mc;
    localparam int CH = 2, AW = 10, LW = 10, DW = 8;

    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, hlda = 1'b1;
    logic [CH-1:0] trig = '0;
    logic [AW-1:0] cfg_src [CH];
    logic [AW-1:0] cfg_dst [CH];
    logic [LW-1:0] cfg_len [CH];
    logic [DW-1:0] cfg_fill [CH];
    logic [CH-1:0] cfg_mode = '0;
    logic [CH*AW-1:0] p_src, p_dst;
    logic [CH*LW-1:0] p_len;
    logic [CH*DW-1:0] p_fill;
    logic hrq, src_ce, dst_we, busy;
    logic [AW-1:0] src_a, dst_a;
    logic [DW-1:0] src_d = '0, dst_d;
    logic [1:0] act;
    logic [CH-1:0] done;
    logic [DW-1:0] mem [1024];

    assign p_src = {cfg_src[1], cfg_src[0]};
    assign p_dst = {cfg_dst[1], cfg_dst[0]};
    assign p_len = {cfg_len[1], cfg_len[0]};
    assign p_fill = {cfg_fill[1], cfg_fill[0]};

    dkong_dma_mc #(.CHANNELS(CH), .AW(AW), .LEN_W(LW), .DW(DW)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_CLK_EN(clk_en), .I_TRIG(trig),
        .I_CFG_SRC(p_src), .I_CFG_DST(p_dst), .I_CFG_LEN(p_len),
        .I_CFG_MODE(cfg_mode), .I_FILL_D(p_fill), .I_HLDA(hlda),
        .O_HRQ(hrq), .O_SRC_A(src_a), .O_SRC_CE(src_ce), .I_SRC_D(src_d),
        .O_DST_A(dst_a), .O_DST_D(dst_d), .O_DST_WE(dst_we), .O_BUSY(busy),
        .O_ACT_CH(act), .O_DONE(done)
    );

    always #5 clk = ~clk;

    // synchronous source RAM, one clock of read latency
    always @(posedge clk) if (src_ce) src_d <= mem[src_a];

    int n_cmp = 0, n_fail = 0;
    int hlda_mode = 0, ph = 0, pause_left = 0, pause_fired = 0;
    int n_tick = 0, first_st = -1, done_tick = -1, rd_cnt = 0, hrq_seen = 0;
    logic en_prev = 1'b0;
    logic [17:0] wlog [$];
    int dlog [$];

    // model state: one job at a time, pending bits, step counter
    int m_phase = 0, m_step = 0, j_ch = 0, j_len = 0, j_src = 0, j_dst = 0;
    logic j_mode = 1'b0;
    logic [DW-1:0] j_fill = '0;
    logic [CH-1:0] m_pend = '0, m_prev = '0;
    logic e_hrq = 0, e_src_ce = 0, e_dst_we = 0, e_busy = 0;
    logic [AW-1:0] e_src_a = '0, e_dst_a = '0;
    logic [DW-1:0] e_dst_d = '0;
    logic [1:0] e_act = '0;
    logic [CH-1:0] e_done = '0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_step = 0; m_pend = '0; m_prev = '0;
        e_hrq = 0; e_src_ce = 0; e_dst_we = 0; e_busy = 0;
        e_src_a = '0; e_dst_a = '0; e_dst_d = '0; e_act = '0; e_done = '0;
    endtask

    task automatic model_tick();
        logic [CH-1:0] rise;
        int was, fin, ch;
        rise = trig & ~m_prev;
        m_prev = trig;
        was = (m_phase != 0);
        e_src_ce = 0; e_dst_we = 0; e_done = '0;
        if (m_phase == 0) begin
            if (m_pend != 0) begin
                ch = 0;
                for (int c = CH - 1; c >= 0; c--) if (m_pend[c]) ch = c;
                m_pend[ch] = 1'b0;
                j_ch = ch; j_src = cfg_src[ch]; j_dst = cfg_dst[ch];
                j_len = cfg_len[ch]; j_mode = cfg_mode[ch]; j_fill = cfg_fill[ch];
                e_act = 2'(ch);
                if (j_len == 0) e_done[ch] = 1'b1;
                else begin m_phase = 1; e_hrq = 1; end
            end
        end else if (m_phase == 1) begin
            if (hlda) begin m_phase = 2; m_step = 0; end
        end else if (hlda) begin
            if (!j_mode) begin
                if (m_step < j_len) begin e_src_ce = 1; e_src_a = AW'((j_src + m_step) % 1024); end
                if (m_step >= 1) begin
                    e_dst_we = 1;
                    e_dst_a = AW'((j_dst + m_step - 1) % 1024);
                    e_dst_d = mem[(j_src + m_step - 1) % 1024];
                end
                fin = (m_step == j_len);
            end else begin
                e_dst_we = 1;
                e_dst_a = AW'((j_dst + m_step) % 1024);
                e_dst_d = j_fill;
                fin = (m_step == j_len - 1);
            end
            m_step++;
            if (fin != 0) begin m_phase = 0; e_hrq = 0; e_done[j_ch] = 1'b1; end
        end
        m_pend = m_pend | rise;
        e_busy = was != 0 || m_phase != 0;
    endtask

    // clock-enable and bus-grant generator, changes 1 ns after the clock edge
    initial forever begin
        @(posedge clk); #1;
        ph = (ph + 1) % 4;
        clk_en = (ph == 0);
        if (hlda_mode != 2) pause_fired = 0;
        if (ph == 2) begin
            if (hlda_mode == 0) hlda = 1'b1;
            else if (hlda_mode == 1) hlda = ($urandom_range(0, 3) != 0);
            else begin
                if (pause_fired == 0 && wlog.size() >= 2) begin pause_left = 3; pause_fired = 1; end
                if (pause_left > 0) begin hlda = 1'b0; pause_left--; end
                else hlda = 1'b1;
            end
        end
    end

    // compare process: check every clock, log events, then advance the model
    initial forever begin
        @(negedge clk);
        if (rst) model_reset();
        chk("hrq", 32'(hrq), 32'(e_hrq));
        chk("src_ce", 32'(src_ce), 32'(e_src_ce));
        chk("src_a", 32'(src_a), 32'(e_src_a));
        chk("dst_we", 32'(dst_we), 32'(e_dst_we));
        chk("dst_a", 32'(dst_a), 32'(e_dst_a));
        chk("dst_d", 32'(dst_d), 32'(e_dst_d));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("act_ch", 32'(act), 32'(e_act));
        chk("done", 32'(done), 32'(e_done));
        if (en_prev) n_tick++;
        if (dst_we) wlog.push_back({dst_a, dst_d});
        if (src_ce) rd_cnt++;
        if ((src_ce || dst_we) && first_st < 0) first_st = n_tick;
        for (int c = 0; c < CH; c++) if (done[c]) begin dlog.push_back(c); done_tick = n_tick; end
        if (hrq) hrq_seen = 1;
        if (!rst) begin
            if (clk_en) model_tick();
            else begin e_src_ce = 0; e_dst_we = 0; e_done = '0; e_busy = (m_phase != 0); end
        end
        en_prev = clk_en;
    end

    task automatic next_tick();
        @(posedge clk iff clk_en);
        #2;
    endtask

    task automatic pulse(input logic [CH-1:0] m);
        trig = trig | m;
        next_tick();
        trig = trig & ~m;
        next_tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_phase != 0 || m_pend != 0) && n < budget) begin next_tick(); n++; end
        if (n >= budget) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: still active after %0d ticks, required idle", budget);
        end
        next_tick();
        next_tick();
    endtask

    task automatic clear_logs();
        wlog.delete(); dlog.delete();
        rd_cnt = 0; first_st = -1; done_tick = -1; hrq_seen = 0;
    endtask

    task automatic setcfg(input int c, input int s, input int d, input int l, input logic md, input logic [7:0] f);
        cfg_src[c] = AW'(s); cfg_dst[c] = AW'(d); cfg_len[c] = LW'(l);
        cfg_mode[c] = md; cfg_fill[c] = f;
    endtask

    function automatic logic [31:0] wl(input int i);
        return (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int n;
        logic [17:0] exp_copy [4];
        exp_copy[0] = {10'h000, 8'h5A}; exp_copy[1] = {10'h001, 8'h5B};
        exp_copy[2] = {10'h002, 8'h58}; exp_copy[3] = {10'h003, 8'h59};
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a) ^ 8'h5A;
        for (int c = 0; c < CH; c++) setcfg(c, 0, 0, 0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset_hrq", 32'(hrq), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dst_a", 32'(dst_a), 0);
        repeat (2) next_tick();

        // copy, grant tied high
        hlda_mode = 0;
        setcfg(0, 'h100, 'h000, 4, 1'b0, 8'h00);
        clear_logs(); pulse(2'b01); wait_idle(100);
        chk("copy_nwr", wlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("copy_wr", wl(i), 32'(exp_copy[i]));
        chk("copy_nrd", rd_cnt, 4);
        chk("copy_ticks", done_tick - first_st + 1, 5);
        chk("copy_ndone", dlog.size(), 1);
        chk("copy_hrq_end", 32'(hrq), 0);

        // fill with address wrap
        setcfg(1, 'h000, 'h3FE, 3, 1'b1, 8'hA5);
        clear_logs(); pulse(2'b10); wait_idle(100);
        chk("fill_w0", wl(0), {14'h0, 10'h3FE, 8'hA5});
        chk("fill_w1", wl(1), {14'h0, 10'h3FF, 8'hA5});
        chk("fill_w2", wl(2), {14'h0, 10'h000, 8'hA5});
        chk("fill_nrd", rd_cnt, 0);
        chk("fill_done_ch", dlog.size() == 1 ? dlog[0] : -1, 1);

        // simultaneous triggers: channel 0 first, channel 1 follows
        setcfg(0, 'h010, 'h200, 3, 1'b0, 8'h00);
        setcfg(1, 'h000, 'h300, 2, 1'b1, 8'h3C);
        clear_logs(); pulse(2'b11); wait_idle(200);
        chk("arb_ndone", dlog.size(), 2);
        chk("arb_first", dlog.size() > 0 ? dlog[0] : -1, 0);
        chk("arb_second", dlog.size() > 1 ? dlog[1] : -1, 1);
        chk("arb_w3", wl(3), {14'h0, 10'h300, 8'h3C});

        // three ungranted ticks after the second write
        hlda_mode = 2;
        setcfg(0, 'h100, 'h080, 4, 1'b0, 8'h00);
        clear_logs(); pulse(2'b01); wait_idle(200);
        chk("pause_ticks", done_tick - first_st + 1, 8);
        chk("pause_nwr", wlog.size(), 4);
        chk("pause_w3", wl(3), {14'h0, 10'h083, 8'h59});
        hlda_mode = 0;
        next_tick();

        // zero length
        setcfg(0, 'h000, 'h000, 0, 1'b0, 8'h00);
        clear_logs(); pulse(2'b01); wait_idle(50);
        chk("len0_hrq_seen", hrq_seen, 0);
        chk("len0_ndone", dlog.size(), 1);

        // reset in the middle of a copy
        setcfg(0, 'h000, 'h100, 8, 1'b0, 8'h00);
        clear_logs(); pulse(2'b01);
        n = 0;
        while (!(m_phase == 2 && m_step >= 3) && n < 100) begin next_tick(); n++; end
        chk("rst_reach_xfer", 32'(n < 100), 1);
        rst = 1'b1;
        #1;
        chk("rst_hrq_now", 32'(hrq), 0);
        chk("rst_busy_now", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (12) next_tick();
        chk("rst_no_done", dlog.size(), 0);
        chk("rst_hrq_after", 32'(hrq), 0);

        // re-triggers during a transfer coalesce into one follow-up
        setcfg(0, 'h040, 'h140, 6, 1'b0, 8'h00);
        clear_logs(); pulse(2'b01);
        n = 0;
        while (m_phase != 2 && n < 100) begin next_tick(); n++; end
        pulse(2'b01); pulse(2'b01);
        wait_idle(200);
        chk("retrig_ndone", dlog.size(), 2);
        chk("retrig_nwr", wlog.size(), 12);

        // randomized traffic with random grant and config churn
        hlda_mode = 1;
        for (int it = 0; it < 60; it++) begin
            for (int c = 0; c < CH; c++)
                setcfg(c, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 6),
                       1'($urandom_range(0, 1)), 8'($urandom));
            pulse(2'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 8)) begin
                if ($urandom_range(0, 3) == 0)
                    setcfg($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                           $urandom_range(0, 6), 1'($urandom_range(0, 1)), 8'($urandom));
                next_tick();
            end
            if ($urandom_range(0, 2) == 0) pulse(2'($urandom_range(1, 3)));
            if ($urandom_range(0, 1) == 0) wait_idle(400);
        end
        wait_idle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
